dcache_resp_model: RTL and testbench
====================================

Name: dcache_resp_model

Overview:
- Behavioural responder for the core's HPDC request/response interface: the far end of the core-to-dcache channel.
- Accepts one request per cycle via valid/ready, executes it against a word-addressed local memory (loads, stores, LR/SC, AMO swap/add), and returns the tagged response a fixed number of cycles later.
- Used in core-tile simulation and unit benches in place of the HPDC. Also generates `wbuf_empty` and programmable back-pressure.

Parameters:
- MEM_WORDS, 1024, number of 64-bit memory words (power of two).
- LATENCY, 2, cycles from request acceptance to `rsp_valid_o` (legal range 1..8).
- READY_PERIOD, 0, when nonzero, `req_ready_o` is forced low for one cycle out of every READY_PERIOD cycles; 0 means never.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  hpdcache_req_op_t  operation
- req_addr_i  in  49  byte address
- req_be_i  in  8  byte enables (stores)
- req_wdata_i  in  64  lane-aligned write data / AMO operand / SC data
- req_size_i  in  2  log2 bytes; AMO/SC accept only 2 or 3
- req_tid_i  in  7  transaction tag
- req_need_rsp_i  in  1  response required
- rsp_valid_o  out  1  response valid (no back-pressure)
- rsp_tid_o  out  7  tag of the response
- rsp_rdata_o  out  64  response data
- rsp_error_o  out  1  error flag
- wbuf_empty_o  out  1  no write-type op in flight

Behaviour:
- Reset (async, rstn_i low):
  - Memory cleared to 0, pipeline emptied, reservation invalid, back-pressure counter = 0.
  - Outputs: rsp_valid_o=0, rsp_tid_o=0, rsp_rdata_o=0, rsp_error_o=0, wbuf_empty_o=1, req_ready_o=1 (or 0 if READY_PERIOD==1).
  - Reset mid-operation discards all in-flight responses; none are emitted after reset release.
- Accept: a request is accepted on a rising edge where `req_valid_i & req_ready_o` is high.
- Ready: `req_ready_o = ~(READY_PERIOD!=0 && cnt==READY_PERIOD-1)`.
  - `cnt` is a free-running counter, modulo READY_PERIOD.
  - Ready does not depend on req_valid_i.
- Index: `idx = addr[3 +: log2(MEM_WORDS)]`.
  - Out of range when `addr >> 3 >= MEM_WORDS`.
  - Out-of-range or unsupported op produces error: rdata=0, error=1, no state change.
- Execution happens at the acceptance edge.
  - Memory and reservation update on that edge.
  - Read data is captured pre-update, so back-to-back ops see prior writes.
- LOAD: rdata = mem[idx] (full aligned word; the core extracts lanes). Memory unchanged.
- STORE: bytes with be=1 overwrite mem[idx]. rdata=0.
- AMO_LR: rdata = mem[idx]; reservation set to {valid, idx}.
- AMO_SC:
  - Reservation valid and idx matches: write wdata (size 3: all bytes; size 2: half selected by addr[2]), rdata=0.
  - Otherwise: no write, rdata=1.
  - Reservation cleared in both cases.
- AMO_SWAP / AMO_ADD:
  - rdata = old mem[idx].
  - Size 3: new = wdata, or old+wdata (mod 2^64).
  - Size 2: operates only on the 32-bit half selected by addr[2] (mod 2^32); the other half is unchanged.
- Any successful STORE/SC/SWAP/ADD to the reserved idx invalidates the reservation.
- Other ops, and AMO/SC with size<2: error.
- Response pipeline:
  - LATENCY-stage shift register of {valid, tid, rdata, error, is_write}.
  - Request accepted at edge N drives rsp_valid_o=1 during the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles later, for one cycle.
  - Responses come out in acceptance order; one per cycle at most.
  - `req_need_rsp_i=0`: the op executes, but its stage valid=0.
  - When rsp_valid_o=0, rsp_tid_o/rdata/error hold 0.
- wbuf_empty_o = no pipeline stage holds a STORE/SC/SWAP/ADD (tracked regardless of need_rsp), registered with the pipeline.
- Tags are not checked for uniqueness.

Test Plan:
- Reset, LATENCY=2: STORE addr 0x10, be=0xFF, wdata 0x1122334455667788, tid 5; then LOAD 0x10, tid 6 on the next cycle.
  - Expect rsp tid5 rdata 0 at cycle+2, then tid6 rdata 0x1122334455667788 at cycle+3.
  - wbuf_empty_o low for 2 cycles after the store.
- Byte store: STORE addr 0x13, be=0x08, wdata 0x00000000AB000000, then LOAD 0x10 → 0x11223344AB667788.
- LR/SC pair:
  - LR 0x20, then SC 0x20 wdata 7 size 3 → SC rdata 0; LOAD 0x20 = 7.
  - Repeat the SC without a new LR → rdata 1, memory unchanged.
  - LR 0x20, STORE 0x20, SC 0x20 → rdata 1.
- AMO_ADD size 2 at addr 0x34 on word 0x00000005_FFFFFFFF, wdata 0x00000003_00000000 → rdata 0x00000005FFFFFFFF; memory becomes 0x00000008FFFFFFFF.
- Errors:
  - LOAD addr 0x2000 (MEM_WORDS=1024) → error=1, rdata=0.
  - STORE with need_rsp=0 → no rsp_valid pulse, memory written.
- READY_PERIOD=3 with req_valid_i held high for 9 cycles → exactly 6 accepts, 6 responses in order with tids intact.
- Assert rstn_i while 2 responses are in flight → no rsp_valid after release, wbuf_empty_o=1.

Source files
------------

// File: rtl/dcache_resp_model.sv
// Behavioural far-end responder for the core's HPDC request/response channel.
// Executes loads, stores, LR/SC and AMO swap/add against a word-addressed
// local memory at the acceptance edge and returns the tagged response a
// fixed LATENCY cycles later. Also produces wbuf_empty and periodic
// back-pressure on the request side.

package dcache_resp_model_pkg;

  typedef enum logic [3:0] {
    HPDCACHE_REQ_LOAD     = 4'h0,
    HPDCACHE_REQ_STORE    = 4'h1,
    HPDCACHE_REQ_AMO_LR   = 4'h4,
    HPDCACHE_REQ_AMO_SC   = 4'h5,
    HPDCACHE_REQ_AMO_SWAP = 4'h6,
    HPDCACHE_REQ_AMO_ADD  = 4'h7,
    HPDCACHE_REQ_AMO_AND  = 4'h8,
    HPDCACHE_REQ_AMO_OR   = 4'h9,
    HPDCACHE_REQ_AMO_XOR  = 4'ha,
    HPDCACHE_REQ_AMO_MAX  = 4'hb,
    HPDCACHE_REQ_AMO_MAXU = 4'hc,
    HPDCACHE_REQ_AMO_MIN  = 4'hd,
    HPDCACHE_REQ_AMO_MINU = 4'he,
    HPDCACHE_REQ_CMO      = 4'hf
  } hpdcache_req_op_t;

  typedef struct packed {
    logic [6:0]  tid;
    logic [63:0] rdata;
    logic        err;
  } rsp_stage_t;

endpackage

module dcache_resp_model
  import dcache_resp_model_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned READY_PERIOD = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  hpdcache_req_op_t req_op_i,
  input  logic [48:0]      req_addr_i,
  input  logic [7:0]       req_be_i,
  input  logic [63:0]      req_wdata_i,
  input  logic [1:0]       req_size_i,
  input  logic [6:0]       req_tid_i,
  input  logic             req_need_rsp_i,
  output logic             rsp_valid_o,
  output logic [6:0]       rsp_tid_o,
  output logic [63:0]      rsp_rdata_o,
  output logic             rsp_error_o,
  output logic             wbuf_empty_o
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

  // Expand per-byte enables into a 64-bit lane mask.
  function automatic logic [63:0] be_to_mask(input logic [7:0] be);
    logic [63:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

  // Replace one 32-bit half of a word, leaving the other half untouched.
  function automatic logic [63:0] merge_half(input logic [63:0] word,
                                             input logic        hi,
                                             input logic [31:0] half);
    return hi ? {half, word[31:0]} : {word[63:32], half};
  endfunction

  // Architectural state
  logic [63:0]      mem [MEM_WORDS];
  logic             resv_vld;
  logic [IDX_W-1:0] resv_idx;
  logic [CNT_W-1:0] cnt;

  // Execute-at-accept signals
  logic             accept;
  logic             word_oor;
  logic             is_amo;
  logic             op_known;
  logic             exec_err;
  logic             exec_wr_op;
  logic             hi;
  logic [IDX_W-1:0] idx;
  logic [63:0]      old_word;
  logic [63:0]      new_word;
  logic [63:0]      exec_rdata;
  logic [31:0]      old_half;
  logic [31:0]      opnd_half;
  logic             mem_we;
  logic             resv_set;
  logic             resv_clr;
  logic             addr_lsb_unused;

  // Response pipeline: bit/element s is stage s, the last stage drives the outputs
  logic [LATENCY-1:0]       vld_p;
  logic [LATENCY-1:0]       wr_p;
  rsp_stage_t [LATENCY-1:0] dat_p;
  logic [LATENCY:0]         vld_sh;
  logic [LATENCY:0]         wr_sh;
  rsp_stage_t [LATENCY:0]   dat_sh;
  rsp_stage_t               exec_rsp;

  assign addr_lsb_unused = ^req_addr_i[1:0];

  assign req_ready_o = ~((READY_PERIOD != 0) && (cnt == CNT_W'(READY_PERIOD - 1)));
  assign accept      = req_valid_i & req_ready_o;

  // Free-running back-pressure phase counter, wraps at READY_PERIOD.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (READY_PERIOD > 1) begin
      cnt <= (cnt == CNT_W'(READY_PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Decode the request and compute read data, new memory word and reservation effect.
  always_comb begin
    word_oor   = (req_addr_i[48:3] >= 46'(MEM_WORDS));
    idx        = req_addr_i[3 +: IDX_W];
    hi         = req_addr_i[2];
    old_word   = mem[idx];
    old_half   = hi ? old_word[63:32] : old_word[31:0];
    opnd_half  = hi ? req_wdata_i[63:32] : req_wdata_i[31:0];
    is_amo     = (req_op_i == HPDCACHE_REQ_AMO_LR)   || (req_op_i == HPDCACHE_REQ_AMO_SC) ||
                 (req_op_i == HPDCACHE_REQ_AMO_SWAP) || (req_op_i == HPDCACHE_REQ_AMO_ADD);
    op_known   = is_amo || (req_op_i == HPDCACHE_REQ_LOAD) || (req_op_i == HPDCACHE_REQ_STORE);
    exec_wr_op = (req_op_i == HPDCACHE_REQ_STORE)    || (req_op_i == HPDCACHE_REQ_AMO_SC) ||
                 (req_op_i == HPDCACHE_REQ_AMO_SWAP) || (req_op_i == HPDCACHE_REQ_AMO_ADD);
    // AMO/SC are only defined for word and double-word sizes
    exec_err   = word_oor || !op_known || (is_amo && !req_size_i[1]);
    exec_rdata = '0;
    new_word   = old_word;
    mem_we     = 1'b0;
    resv_set   = 1'b0;
    resv_clr   = 1'b0;
    if (!exec_err) begin
      case (req_op_i)
        HPDCACHE_REQ_LOAD: begin
          exec_rdata = old_word;
        end
        HPDCACHE_REQ_STORE: begin
          new_word = (old_word & ~be_to_mask(req_be_i)) | (req_wdata_i & be_to_mask(req_be_i));
          mem_we   = 1'b1;
        end
        HPDCACHE_REQ_AMO_LR: begin
          exec_rdata = old_word;
          resv_set   = 1'b1;
        end
        HPDCACHE_REQ_AMO_SC: begin
          resv_clr = 1'b1;
          if (resv_vld && (resv_idx == idx)) begin
            mem_we   = 1'b1;
            new_word = req_size_i[0] ? req_wdata_i : merge_half(old_word, hi, opnd_half);
          end else begin
            exec_rdata = 64'd1;
          end
        end
        HPDCACHE_REQ_AMO_SWAP: begin
          exec_rdata = old_word;
          mem_we     = 1'b1;
          new_word   = req_size_i[0] ? req_wdata_i : merge_half(old_word, hi, opnd_half);
        end
        HPDCACHE_REQ_AMO_ADD: begin
          exec_rdata = old_word;
          mem_we     = 1'b1;
          new_word   = req_size_i[0] ? (old_word + req_wdata_i)
                                     : merge_half(old_word, hi, old_half + opnd_half);
        end
        default: begin
        end
      endcase
    end
    // Any write landing on the reserved word breaks the reservation
    if (mem_we && resv_vld && (resv_idx == idx)) begin
      resv_clr = 1'b1;
    end
  end

  // Memory array: cleared on reset, written at the acceptance edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        mem[i[IDX_W-1:0]] <= '0;
      end
    end else if (accept && mem_we) begin
      mem[idx] <= new_word;
    end
  end

  // LR/SC reservation: LR sets it, SC or a conflicting write clears it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resv_vld <= 1'b0;
      resv_idx <= '0;
    end else if (accept) begin
      if (resv_set) begin
        resv_vld <= 1'b1;
        resv_idx <= idx;
      end else if (resv_clr) begin
        resv_vld <= 1'b0;
      end
    end
  end

  // ---- stage boundary: acceptance edge -> response pipeline stage 0 ----
  assign exec_rsp.tid   = req_tid_i;
  assign exec_rsp.rdata = exec_rdata;
  assign exec_rsp.err   = exec_err;

  assign vld_sh = {vld_p, accept & req_need_rsp_i};
  assign wr_sh  = {wr_p,  accept & exec_wr_op};
  assign dat_sh = {dat_p, exec_rsp};

  // Pipeline control bits: response valid and write-in-flight markers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p <= '0;
      wr_p  <= '0;
    end else begin
      vld_p <= vld_sh[LATENCY-1:0];
      wr_p  <= wr_sh[LATENCY-1:0];
    end
  end

  // Pipeline payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    dat_p <= dat_sh[LATENCY-1:0];
  end

  // ---- stage boundary: last pipeline stage -> response outputs ----
  assign rsp_valid_o  = vld_p[LATENCY-1];
  assign rsp_tid_o    = rsp_valid_o ? dat_p[LATENCY-1].tid   : '0;
  assign rsp_rdata_o  = rsp_valid_o ? dat_p[LATENCY-1].rdata : '0;
  assign rsp_error_o  = rsp_valid_o ? dat_p[LATENCY-1].err   : 1'b0;
  assign wbuf_empty_o = ~|wr_p;

endmodule

// File: tb/tb_dcache_resp_model.sv
// Bench for dcache_resp_model: randomized and directed requests checked every
// cycle against a behavioural memory/reservation/response-queue model, plus
// literal expectations on selected responses.

module tb_dcache_resp_model;
  import dcache_resp_model_pkg::*;

  localparam int MEM_WORDS    = 1024;
  localparam int LATENCY      = 2;
  localparam int READY_PERIOD = 3;

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  hpdcache_req_op_t req_op_i = HPDCACHE_REQ_LOAD;
  logic [48:0]      req_addr_i = '0;
  logic [7:0]       req_be_i = '0;
  logic [63:0]      req_wdata_i = '0;
  logic [1:0]       req_size_i = 2'd3;
  logic [6:0]       req_tid_i = '0;
  logic             req_need_rsp_i = 1'b1;
  logic             rsp_valid_o;
  logic [6:0]       rsp_tid_o;
  logic [63:0]      rsp_rdata_o;
  logic             rsp_error_o;
  logic             wbuf_empty_o;

  always #5 clk_i = ~clk_i;

  dcache_resp_model #(
    .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .READY_PERIOD(READY_PERIOD)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_be_i(req_be_i),
    .req_wdata_i(req_wdata_i), .req_size_i(req_size_i), .req_tid_i(req_tid_i),
    .req_need_rsp_i(req_need_rsp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tid_o(rsp_tid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o), .wbuf_empty_o(wbuf_empty_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [6:0]  tid;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic [63:0] mmem [MEM_WORDS];
  bit          mrv;
  int          mridx;
  int          ecount;
  bit          have_wr;
  int          last_wr;
  exp_t        expq[$];

  logic [63:0] log_rdata [128];
  logic        log_err [128];
  int          log_seen [128];
  int          rsp_cnt = 0;

  task automatic model_exec(input hpdcache_req_op_t op, input logic [48:0] a,
                            input logic [7:0] be, input logic [63:0] wd, input logic [1:0] sz,
                            output logic [63:0] rd, output logic er, output logic wr);
    logic [63:0] old;
    logic [63:0] nw;
    int idx;
    int h;
    bit amo;
    amo = op inside {HPDCACHE_REQ_AMO_LR, HPDCACHE_REQ_AMO_SC,
                     HPDCACHE_REQ_AMO_SWAP, HPDCACHE_REQ_AMO_ADD};
    wr  = op inside {HPDCACHE_REQ_STORE, HPDCACHE_REQ_AMO_SC,
                     HPDCACHE_REQ_AMO_SWAP, HPDCACHE_REQ_AMO_ADD};
    rd = '0;
    er = 1'b0;
    if ((a >> 3) >= 49'(MEM_WORDS) || !(amo || op == HPDCACHE_REQ_LOAD || op == HPDCACHE_REQ_STORE)
        || (amo && sz < 2'd2)) begin
      er = 1'b1;
      return;
    end
    idx = int'(a >> 3);
    h   = int'(a[2]);
    old = mmem[idx];
    nw  = old;
    case (op)
      HPDCACHE_REQ_LOAD: rd = old;
      HPDCACHE_REQ_STORE: begin
        for (int b = 0; b < 8; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
        mmem[idx] = nw;
        if (mrv && mridx == idx) mrv = 0;
      end
      HPDCACHE_REQ_AMO_LR: begin
        rd = old;
        mrv = 1;
        mridx = idx;
      end
      HPDCACHE_REQ_AMO_SC: begin
        if (mrv && mridx == idx) begin
          if (sz == 2'd3) nw = wd;
          else nw[32*h +: 32] = wd[32*h +: 32];
          mmem[idx] = nw;
        end else begin
          rd = 64'd1;
        end
        mrv = 0;
      end
      HPDCACHE_REQ_AMO_SWAP, HPDCACHE_REQ_AMO_ADD: begin
        rd = old;
        if (sz == 2'd3) nw = (op == HPDCACHE_REQ_AMO_SWAP) ? wd : old + wd;
        else nw[32*h +: 32] = (op == HPDCACHE_REQ_AMO_SWAP) ? wd[32*h +: 32]
                                                            : old[32*h +: 32] + wd[32*h +: 32];
        mmem[idx] = nw;
        if (mrv && mridx == idx) mrv = 0;
      end
      default: ;
    endcase
  endtask

  // Model update at each edge; asynchronous reset wipes all model state.
  always @(posedge clk_i or negedge rstn_i) begin
    logic [63:0] rd;
    logic er;
    logic wr;
    bit rdy;
    if (!rstn_i) begin
      foreach (mmem[i]) mmem[i] = '0;
      mrv = 0;
      mridx = 0;
      ecount = 0;
      have_wr = 0;
      last_wr = 0;
      expq.delete();
    end else begin
      rdy = (ecount % READY_PERIOD) != (READY_PERIOD - 1);
      ecount++;
      if (req_valid_i && rdy) begin
        model_exec(req_op_i, req_addr_i, req_be_i, req_wdata_i, req_size_i, rd, er, wr);
        if (wr) begin
          have_wr = 1;
          last_wr = ecount;
        end
        if (req_need_rsp_i)
          expq.push_back('{due: ecount + LATENCY - 1, tid: req_tid_i, rdata: rd, err: er});
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk_i) begin
    exp_t e;
    bit ev;
    if (!rstn_i) begin
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_tid", rsp_tid_o, 0);
      chk("rst_rsp_rdata", rsp_rdata_o, 0);
      chk("rst_rsp_error", rsp_error_o, 0);
      chk("rst_wbuf_empty", wbuf_empty_o, 1);
      chk("rst_req_ready", req_ready_o, 1);
    end else begin
      ev = (expq.size() > 0) && (expq[0].due == ecount);
      chk("req_ready", req_ready_o, (ecount % READY_PERIOD) != (READY_PERIOD - 1));
      chk("wbuf_empty", wbuf_empty_o, !(have_wr && (ecount - last_wr) < LATENCY));
      chk("rsp_valid", rsp_valid_o, ev);
      if (ev) begin
        e = expq.pop_front();
        chk("rsp_tid", rsp_tid_o, e.tid);
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_error", rsp_error_o, e.err);
      end else begin
        chk("idle_tid", rsp_tid_o, 0);
        chk("idle_rdata", rsp_rdata_o, 0);
        chk("idle_error", rsp_error_o, 0);
      end
      if (rsp_valid_o) begin
        rsp_cnt++;
        log_rdata[rsp_tid_o] = rsp_rdata_o;
        log_err[rsp_tid_o]   = rsp_error_o;
        log_seen[rsp_tid_o]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called and returning at posedge+1; returns right after the accepting edge.
  task automatic send(input hpdcache_req_op_t op, input logic [48:0] addr, input logic [7:0] be,
                      input logic [63:0] wd, input logic [1:0] sz, input logic [6:0] tid,
                      input logic need);
    int guard;
    bit acc;
    guard = 0;
    req_valid_i = 1'b1;
    req_op_i = op;
    req_addr_i = addr;
    req_be_i = be;
    req_wdata_i = wd;
    req_size_i = sz;
    req_tid_i = tid;
    req_need_rsp_i = need;
    acc = 0;
    while (!acc && guard < 10) begin
      @(negedge clk_i);
      acc = req_ready_o;
      @(posedge clk_i);
      #1;
      guard++;
    end
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout tid=%0d actual=not_accepted expected=accepted", tid);
    end
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    repeat (LATENCY + 3) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int a;
    int r0;
    logic [3:0] rop;
    int r;
    foreach (log_rdata[i]) begin
      log_rdata[i] = 64'hDEAD_BEEF_DEAD_BEEF;
      log_err[i] = 1'bx;
      log_seen[i] = 0;
    end

    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    // store then load back-to-back
    send(HPDCACHE_REQ_STORE, 49'h10, 8'hFF, 64'h1122334455667788, 2'd3, 7'd5, 1'b1);
    send(HPDCACHE_REQ_LOAD,  49'h10, 8'h00, 64'h0, 2'd3, 7'd6, 1'b1);
    drain();
    chk("store_rdata", log_rdata[5], 64'h0);
    chk("load_after_store", log_rdata[6], 64'h1122334455667788);

    // byte store
    send(HPDCACHE_REQ_STORE, 49'h13, 8'h08, 64'h00000000AB000000, 2'd3, 7'd7, 1'b1);
    send(HPDCACHE_REQ_LOAD,  49'h10, 8'h00, 64'h0, 2'd3, 7'd8, 1'b1);
    drain();
    chk("byte_store_load", log_rdata[8], 64'h11223344AB667788);
    chk("model_byte_store", mmem[2], 64'h11223344AB667788);

    // LR/SC
    send(HPDCACHE_REQ_AMO_LR,  49'h20, 8'h00, 64'h0, 2'd3, 7'd9,  1'b1);
    send(HPDCACHE_REQ_AMO_SC,  49'h20, 8'h00, 64'd7, 2'd3, 7'd10, 1'b1);
    send(HPDCACHE_REQ_LOAD,    49'h20, 8'h00, 64'h0, 2'd3, 7'd11, 1'b1);
    send(HPDCACHE_REQ_AMO_SC,  49'h20, 8'h00, 64'd9, 2'd3, 7'd12, 1'b1);
    send(HPDCACHE_REQ_LOAD,    49'h20, 8'h00, 64'h0, 2'd3, 7'd13, 1'b1);
    send(HPDCACHE_REQ_AMO_LR,  49'h20, 8'h00, 64'h0, 2'd3, 7'd14, 1'b1);
    send(HPDCACHE_REQ_STORE,   49'h20, 8'hFF, 64'h55, 2'd3, 7'd15, 1'b1);
    send(HPDCACHE_REQ_AMO_SC,  49'h20, 8'h00, 64'd3, 2'd3, 7'd16, 1'b1);
    drain();
    chk("sc_success", log_rdata[10], 64'd0);
    chk("load_after_sc", log_rdata[11], 64'd7);
    chk("sc_no_resv", log_rdata[12], 64'd1);
    chk("load_after_failed_sc", log_rdata[13], 64'd7);
    chk("sc_after_store", log_rdata[16], 64'd1);

    // AMO_ADD on the upper 32-bit half
    send(HPDCACHE_REQ_STORE,   49'h30, 8'hFF, 64'h00000005FFFFFFFF, 2'd3, 7'd17, 1'b1);
    send(HPDCACHE_REQ_AMO_ADD, 49'h34, 8'h00, 64'h0000000300000000, 2'd2, 7'd18, 1'b1);
    send(HPDCACHE_REQ_LOAD,    49'h30, 8'h00, 64'h0, 2'd3, 7'd19, 1'b1);
    drain();
    chk("amo_add_old", log_rdata[18], 64'h00000005FFFFFFFF);
    chk("amo_add_new", log_rdata[19], 64'h00000008FFFFFFFF);

    // errors and silent store
    send(HPDCACHE_REQ_LOAD,  49'h2000, 8'h00, 64'h0, 2'd3, 7'd20, 1'b1);
    send(HPDCACHE_REQ_STORE, 49'h40, 8'hFF, 64'hDEAD, 2'd3, 7'd21, 1'b0);
    send(HPDCACHE_REQ_LOAD,  49'h40, 8'h00, 64'h0, 2'd3, 7'd22, 1'b1);
    drain();
    chk("oor_error", log_err[20], 1'b1);
    chk("oor_rdata", log_rdata[20], 64'h0);
    chk("no_rsp_store_silent", log_seen[21], 0);
    chk("no_rsp_store_written", log_rdata[22], 64'hDEAD);

    // back-pressure: valid held for 9 cycles
    a = 0;
    r0 = rsp_cnt;
    req_valid_i = 1'b1;
    req_op_i = HPDCACHE_REQ_LOAD;
    req_addr_i = 49'h10;
    req_need_rsp_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      req_tid_i = 7'(30 + a);
      @(negedge clk_i);
      if (req_ready_o) a++;
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
    drain();
    chk("ready_accepts", a, 6);
    chk("ready_rsps", rsp_cnt - r0, 6);
    for (int t = 30; t < 36; t++) chk("ready_tid_seen", log_seen[t], 1);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      req_valid_i = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      rop = 4'($urandom_range(0, 15));
      req_op_i = (r < 3)  ? HPDCACHE_REQ_LOAD :
                 (r < 6)  ? HPDCACHE_REQ_STORE :
                 (r < 8)  ? HPDCACHE_REQ_AMO_LR :
                 (r < 10) ? HPDCACHE_REQ_AMO_SC :
                 (r < 12) ? HPDCACHE_REQ_AMO_SWAP :
                 (r < 14) ? HPDCACHE_REQ_AMO_ADD : hpdcache_req_op_t'(rop);
      if ($urandom_range(0, 15) == 0)
        req_addr_i = 49'($urandom_range(1024, 5000)) * 49'd8 + 49'($urandom_range(0, 7));
      else
        req_addr_i = 49'($urandom_range(0, 15)) * 49'd8 + 49'($urandom_range(0, 7));
      req_be_i = 8'($urandom);
      req_wdata_i = {$urandom, $urandom};
      req_size_i = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      req_tid_i = 7'(64 + $urandom_range(0, 63));
      req_need_rsp_i = ($urandom_range(0, 3) != 0);
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
    drain();
    chk("queue_drained", expq.size(), 0);

    // reset with two responses in flight
    r0 = rsp_cnt;
    send(HPDCACHE_REQ_STORE, 49'h50, 8'hFF, 64'h1234, 2'd3, 7'd40, 1'b1);
    send(HPDCACHE_REQ_LOAD,  49'h10, 8'h00, 64'h0, 2'd3, 7'd41, 1'b1);
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    chk("reset_flush", rsp_cnt - r0, 0);
    chk("reset_wbuf_empty", wbuf_empty_o, 1);
    send(HPDCACHE_REQ_LOAD, 49'h10, 8'h00, 64'h0, 2'd3, 7'd42, 1'b1);
    send(HPDCACHE_REQ_LOAD, 49'h50, 8'h00, 64'h0, 2'd3, 7'd43, 1'b1);
    drain();
    chk("mem_cleared_10", log_rdata[42], 64'h0);
    chk("mem_cleared_50", log_rdata[43], 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
